// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register scoreboard of pending results.
// Register 0 is hard-wired to zero. Reads are combinational, with optional
// same-cycle forwarding from the write ports. The highest-indexed write port
// wins when several ports target the same register.
module regfile_mp #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_dout,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NWR-1:0]       we,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*WIDTH-1:0] wr_din,
    input  logic                 sb_set,
    input  logic [AW-1:0]        sb_addr
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_r;
    logic [DEPTH-1:0]            busy_r;

    logic [AW-1:0]               wa_s [NWR];
    logic [WIDTH-1:0]            wd_s [NWR];
    logic [NWR-1:0]              wv_s;
    logic                        sb_v_s;
    logic [AW-1:0]               ra_s [NRD];
    logic [NRD*WIDTH-1:0]        rd_dout_s;
    logic [NRD-1:0]              rd_busy_s;

    // An address names a real register only if it is nonzero and below DEPTH.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != {AW{1'b0}}) && (32'(a) < 32'(DEPTH));
    endfunction

    // Unpack the write ports and qualify each with enable and address validity.
    always_comb begin
        for (int j = 0; j < NWR; j++) begin
            wa_s[j] = wr_addr[j*AW +: AW];
            wd_s[j] = wr_din[j*WIDTH +: WIDTH];
            wv_s[j] = we[j] & addr_ok(wa_s[j]);
        end
        sb_v_s = sb_set & addr_ok(sb_addr);
    end

    // Storage and scoreboard update; later ports override earlier ones, and a
    // scoreboard set overrides a same-edge clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_r  <= '0;
            busy_r <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wv_s[j]) begin
                    mem_r[wa_s[j]]  <= wd_s[j];
                    busy_r[wa_s[j]] <= 1'b0;
                end
            end
            if (sb_v_s) begin
                busy_r[sb_addr] <= 1'b1;
            end
        end
    end

    // Combinational read ports with optional forwarding; all zero while in reset.
    always_comb begin
        rd_dout_s = {(NRD*WIDTH){1'b0}};
        rd_busy_s = {NRD{1'b0}};
        for (int i = 0; i < NRD; i++) begin
            ra_s[i] = rd_addr[i*AW +: AW];
            if (rst && addr_ok(ra_s[i])) begin
                rd_dout_s[i*WIDTH +: WIDTH] = mem_r[ra_s[i]];
                rd_busy_s[i]                = busy_r[ra_s[i]];
                // Ascending scan so the highest matching write port is forwarded.
                for (int j = 0; j < NWR; j++) begin
                    if ((BYPASS != 32'sd0) && wv_s[j] && (wa_s[j] == ra_s[i])) begin
                        rd_dout_s[i*WIDTH +: WIDTH] = wd_s[j];
                        rd_busy_s[i]                = 1'b0;
                    end else begin
                        // No forwarding from this port; keep the stored value.
                    end
                end
            end else begin
                rd_dout_s[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
                rd_busy_s[i]                = 1'b0;
            end
        end
    end

    assign rd_dout = rd_dout_s;
    assign rd_busy = rd_busy_s;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: two instances share stimulus, one with
// defaults (forwarding, 32 registers) and one with no forwarding and 24
// registers, each checked against its own array-based reference model.
module tb_regfile_mp;

    localparam int W   = 32;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int AW  = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic [NRD*AW-1:0]  rd_addr;
    logic [NRD*W-1:0]   dout_a, dout_b;
    logic [NRD-1:0]     busy_a, busy_b;
    logic [NWR-1:0]     we;
    logic [NWR*AW-1:0]  wr_addr;
    logic [NWR*W-1:0]   wr_din;
    logic               sb_set;
    logic [AW-1:0]      sb_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_mp dut_a (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_dout(dout_a), .rd_busy(busy_a),
        .we(we), .wr_addr(wr_addr), .wr_din(wr_din), .sb_set(sb_set), .sb_addr(sb_addr)
    );

    regfile_mp #(.DEPTH(24), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_dout(dout_b), .rd_busy(busy_b),
        .we(we), .wr_addr(wr_addr), .wr_din(wr_din), .sb_set(sb_set), .sb_addr(sb_addr)
    );

    // Reference model: k=0 is dut_a, k=1 is dut_b.
    logic [W-1:0] m_mem  [2][32];
    logic         m_busy [2][32];

    typedef struct {
        logic [NRD*W-1:0] da, db;
        logic [NRD-1:0]   ba, bb;
    } exp_t;
    exp_t exp_q[$];

    function automatic int depth_of(input int k);
        return (k == 0) ? 32 : 24;
    endfunction

    function automatic bit real_reg(input int k, input int a);
        return (a != 0) && (a < depth_of(k));
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 32; a++) begin
                m_mem[k][a]  = '0;
                m_busy[k][a] = 1'b0;
            end
    endfunction

    // Value and pending flag the spec promises for address a on instance k right now.
    function automatic void model_read(input int k, input int a, output logic [W-1:0] v, output logic b);
        v = '0;
        b = 1'b0;
        if (rst === 1'b1 && real_reg(k, a)) begin
            v = m_mem[k][a];
            b = m_busy[k][a];
            if (k == 0)
                for (int j = 0; j < NWR; j++)
                    if (we[j] && int'(wr_addr[j*AW +: AW]) == a) begin
                        v = wr_din[j*W +: W];
                        b = 1'b0;
                    end
        end
    endfunction

    function automatic void push_expected();
        exp_t e;
        logic [W-1:0] v;
        logic b;
        for (int i = 0; i < NRD; i++) begin
            model_read(0, int'(rd_addr[i*AW +: AW]), v, b);
            e.da[i*W +: W] = v;
            e.ba[i] = b;
            model_read(1, int'(rd_addr[i*AW +: AW]), v, b);
            e.db[i*W +: W] = v;
            e.bb[i] = b;
        end
        exp_q.push_back(e);
    endfunction

    // Effect of the coming rising edge on the model state.
    function automatic void model_edge();
        if (rst !== 1'b1) begin
            model_clear();
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int j = 0; j < NWR; j++) begin
                    int a;
                    a = int'(wr_addr[j*AW +: AW]);
                    if (we[j] && real_reg(k, a)) begin
                        m_mem[k][a]  = wr_din[j*W +: W];
                        m_busy[k][a] = 1'b0;
                    end
                end
                if (sb_set && real_reg(k, int'(sb_addr)))
                    m_busy[k][int'(sb_addr)] = 1'b1;
            end
        end
    endfunction

    task automatic drive(input logic r, input int r0, input int r1, input logic [1:0] w,
                         input int a0, input int a1, input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic s, input int sa);
        @(negedge clk);
        rst     = r;
        rd_addr = {AW'(r1), AW'(r0)};
        we      = w;
        wr_addr = {AW'(a1), AW'(a0)};
        wr_din  = {d1, d0};
        sb_set  = s;
        sb_addr = AW'(sa);
        push_expected();
        model_edge();
    endtask

    // Reset pulsed low between edges while writes and a scoreboard set are presented.
    task automatic pulse_reset();
        @(negedge clk);
        rd_addr = {5'd4, 5'd9};
        we      = 2'b11;
        wr_addr = {5'd9, 5'd4};
        wr_din  = {32'hCAFE0009, 32'hCAFE0004};
        sb_set  = 1'b1;
        sb_addr = 5'd9;
        #1;
        rst = 1'b0;
        model_clear();
        push_expected();
        #2;
        rst = 1'b1;
        model_edge();
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every queued expectation against the live outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dout_bypass", {{(64-NRD*W){1'b0}}, dout_a}, {{(64-NRD*W){1'b0}}, e.da});
                check("busy_bypass", {{(64-NRD){1'b0}}, busy_a}, {{(64-NRD){1'b0}}, e.ba});
                check("dout_nobyp", {{(64-NRD*W){1'b0}}, dout_b}, {{(64-NRD*W){1'b0}}, e.db});
                check("busy_nobyp", {{(64-NRD){1'b0}}, busy_b}, {{(64-NRD){1'b0}}, e.bb});
            end
        end
    end

    initial begin
        rst = 1'b0; rd_addr = '0; we = '0; wr_addr = '0; wr_din = '0; sb_set = 1'b0; sb_addr = '0;
        model_clear();
        // Held in reset: writes and sets must be ignored, outputs zero.
        for (int c = 0; c < 3; c++)
            drive(1'b0, 5, 6, 2'b11, 5, 6, 32'h11111111, 32'h22222222, 1'b1, 5);
        // Read every address on both ports after reset.
        for (int c = 0; c < 16; c++)
            drive(1'b1, 2*c, 2*c+1, 2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 0);
        // Same-address double write: port 1 wins, forwarded same cycle.
        drive(1'b1, 5, 5, 2'b11, 5, 5, 32'hAAAA0000, 32'h5555FFFF, 1'b0, 0);
        drive(1'b1, 5, 0, 2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 0);
        // Register 0 ignores writes and scoreboard sets.
        drive(1'b1, 0, 0, 2'b01, 0, 0, 32'hDEADBEEF, 32'h0, 1'b1, 0);
        drive(1'b1, 0, 5, 2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 0);
        // Scoreboard set on 7, cleared by a write two cycles later.
        drive(1'b1, 7, 7, 2'b00, 0, 0, 32'h0, 32'h0, 1'b1, 7);
        drive(1'b1, 7, 0, 2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 0);
        drive(1'b1, 7, 0, 2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 0);
        drive(1'b1, 7, 7, 2'b10, 0, 7, 32'h0, 32'h77777777, 1'b0, 0);
        drive(1'b1, 7, 0, 2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 0);
        // Same-edge set and write on 7: set wins.
        drive(1'b1, 7, 0, 2'b01, 7, 0, 32'h70707070, 32'h0, 1'b1, 7);
        drive(1'b1, 7, 7, 2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 0);
        // Write to 3: old value in the write cycle without forwarding.
        drive(1'b1, 3, 3, 2'b01, 3, 0, 32'h12345678, 32'h0, 1'b0, 0);
        drive(1'b1, 3, 3, 2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 0);
        // Addresses beyond the 24-register instance.
        drive(1'b1, 28, 25, 2'b11, 28, 25, 32'hABCD0028, 32'hABCD0025, 1'b1, 28);
        drive(1'b1, 28, 25, 2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 0);
        // Fill 1..31, mark 9 pending, then an asynchronous reset pulse.
        for (int c = 0; c < 16; c++)
            drive(1'b1, 2*c, 9, 2'b11, 2*c, 2*c+1, 32'hF0000000 + 32'(c), 32'hE0000000 + 32'(c), 1'b0, 0);
        drive(1'b1, 9, 30, 2'b00, 0, 0, 32'h0, 32'h0, 1'b1, 9);
        drive(1'b1, 9, 31, 2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 0);
        pulse_reset();
        drive(1'b1, 9, 4, 2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 0);
        drive(1'b1, 31, 1, 2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 0);
        // Randomized traffic, biased toward a few registers to create collisions.
        for (int c = 0; c < 300; c++) begin
            int lim;
            lim = ($urandom_range(0, 1) == 0) ? 7 : 31;
            drive(1'b1, $urandom_range(0, lim), $urandom_range(0, lim), 2'($urandom_range(0, 3)),
                  $urandom_range(0, lim), $urandom_range(0, lim), $urandom, $urandom,
                  1'($urandom_range(0, 1)), $urandom_range(0, lim));
        end
        drive(1'b1, 0, 0, 2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 0);
        @(negedge clk);
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
